wb_stage: RTL and testbench

- Writeback stage of the 5-stage in-order pipeline; the last stage before the register file.
- Accepts one instruction per cycle from the MEM stage via a valid/allowin handshake.
- For loads, waits for the SRAM data_ok, then extracts and extends the byte, half or word.
- Drives the register-file write port (4-bit we, 5-bit waddr, 32-bit wdata), the bypass/stall info for ID, and a retired-instruction counter.

---
 rtl/wb_stage.sv | 115 +++++++++++
 tb/tb_wb_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage; retires MEM-stage instructions into the register file, with load extension and ID bypass.
// Define WB_DEBUG_TRACE_EN to add the debug_wb_* golden-trace ports and the held PC register.
module wb_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_res,
  input  logic        ms_is_load,
  input  logic [2:0]  ms_ld_op,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [3:0]  rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_fwd_valid,
  output logic [4:0]  ws_fwd_dest,
  output logic [31:0] ws_fwd_data,
  output logic        ws_fwd_blocked,
  output logic [31:0] instret
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
`endif
);
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_H  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  logic        r_valid;
  logic        r_gr_we;
  logic        r_is_load;
  logic [4:0]  r_dest;
  logic [31:0] r_res;
  logic [2:0]  r_ld_op;
  logic [31:0] r_instret;
  logic        w_ready_go;
  logic        w_retire;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;

  // A load stays in WB until its data arrives; everything else retires at once.
  assign w_ready_go = ~r_is_load | data_sram_data_ok;
  assign ws_allowin = ~r_valid | w_ready_go;
  assign w_retire   = r_valid & w_ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid   <= 1'b0;
      r_gr_we   <= 1'b0;
      r_is_load <= 1'b0;
      r_dest    <= 5'd0;
      r_res     <= 32'd0;
      r_ld_op   <= 3'd0;
      r_instret <= 32'd0;
    end else begin
      if (ws_allowin) r_valid <= ms_to_ws_valid;
      if (ws_allowin && ms_to_ws_valid) begin
        r_gr_we   <= ms_gr_we;
        r_is_load <= ms_is_load;
        r_dest    <= ms_dest;
        r_res     <= ms_res;
        r_ld_op   <= ms_ld_op;
      end
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

  assign w_byte = data_sram_rdata[{r_res[1:0], 3'b000} +: 8];
  assign w_half = r_res[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];

  always_comb begin
    w_ld_data = (r_ld_op == LD_B)  ? {{24{w_byte[7]}}, w_byte} :
                (r_ld_op == LD_H)  ? {{16{w_half[15]}}, w_half} :
                (r_ld_op == LD_BU) ? {24'd0, w_byte} :
                (r_ld_op == LD_HU) ? {16'd0, w_half} :
                                     data_sram_rdata;
  end

  assign rf_we          = {4{w_retire & r_gr_we}};
  assign rf_waddr       = r_dest;
  assign rf_wdata       = r_is_load ? w_ld_data : r_res;
  assign ws_fwd_valid   = r_valid & r_gr_we & (r_dest != 5'd0);
  assign ws_fwd_dest    = r_dest;
  assign ws_fwd_data    = rf_wdata;
  assign ws_fwd_blocked = ws_fwd_valid & r_is_load & ~data_sram_data_ok;
  assign instret        = r_instret;

`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] r_pc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_pc <= RESET_PC;
    else if (ws_allowin && ms_to_ws_valid) r_pc <= ms_pc;
  end

  assign debug_wb_pc       = r_pc;
  assign debug_wb_rf_we    = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`else
  logic w_unused_pc;
  assign w_unused_pc = ^{ms_pc, RESET_PC};
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed steps from the test plan, then a randomized stream checked against a queue-based model.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_res;
  logic        ms_is_load;
  logic [2:0]  ms_ld_op;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_dest;
  logic [31:0] ws_fwd_data;
  logic        ws_fwd_blocked;
  logic [31:0] instret;

  wb_stage dut (
    .clk(clk), .resetn(resetn), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_res(ms_res),
    .ms_is_load(ms_is_load), .ms_ld_op(ms_ld_op), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_fwd_valid(ws_fwd_valid), .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data),
    .ws_fwd_blocked(ws_fwd_blocked), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [2:0]  op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] res;
  } ins_t;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_instret = 0;
  logic [31:0] prev_res;
  ins_t wb_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Load result straight from the architectural definition of each load kind.
  function automatic logic [31:0] load_val(input logic [2:0] op, input logic [1:0] a, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> (8 * a));
    h = 16'(d >> (16 * a[1]));
    case (op)
      3'd1:    return 32'($signed(b));
      3'd2:    return 32'($signed(h));
      3'd3:    return {24'd0, b};
      3'd4:    return {16'd0, h};
      default: return d;
    endcase
  endfunction

  task automatic offer(input logic ld, input logic [2:0] op, input logic [4:0] dest, input logic [31:0] res);
    ms_to_ws_valid = 1'b1;
    ms_is_load = ld;
    ms_ld_op = op;
    ms_gr_we = 1'b1;
    ms_dest = dest;
    ms_res = res;
    ms_pc = 32'h1c000000 + {res[29:0], 2'b00};
  endtask

  initial begin
    resetn = 1'b0;
    ms_to_ws_valid = 1'b1;
    ms_pc = 32'h1c000000;
    ms_gr_we = 1'b1;
    ms_dest = 5'd3;
    ms_res = 32'h55;
    ms_is_load = 1'b0;
    ms_ld_op = 3'd0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'd0;
    tick();
    tick();
    chk("reset_rf_we", rf_we, 4'h0);
    chk("reset_instret", instret, 32'd0);
    chk("reset_allowin", ws_allowin, 1'b1);
    chk("reset_fwd_valid", ws_fwd_valid, 1'b0);
    chk("reset_fwd_blocked", ws_fwd_blocked, 1'b0);
    ms_to_ws_valid = 1'b0;
    resetn = 1'b1;
    tick();
    chk("post_reset_rf_we", rf_we, 4'h0);

    offer(1'b0, 3'd0, 5'd5, 32'h1234);
    ms_pc = 32'h1c000004;
    #1 chk("alu_allowin", ws_allowin, 1'b1);
    tick();
    ms_to_ws_valid = 1'b0;
    #1;
    chk("alu_rf_we", rf_we, 4'hf);
    chk("alu_waddr", rf_waddr, 5'd5);
    chk("alu_wdata", rf_wdata, 32'h1234);
    chk("alu_fwd_valid", ws_fwd_valid, 1'b1);
    chk("alu_fwd_data", ws_fwd_data, 32'h1234);
    tick();
    exp_instret = 1;
    chk("alu_instret", instret, exp_instret);
    chk("alu_idle_rf_we", rf_we, 4'h0);

    offer(1'b1, 3'd1, 5'd7, 32'h1c000103);
    tick();
    ms_to_ws_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ldb_wait_allowin", ws_allowin, 1'b0);
      chk("ldb_wait_blocked", ws_fwd_blocked, 1'b1);
      chk("ldb_wait_rf_we", rf_we, 4'h0);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h80AABBCC;
    #1;
    chk("ldb_rf_we", rf_we, 4'hf);
    chk("ldb_wdata", rf_wdata, 32'hFFFFFF80);
    chk("ldb_allowin", ws_allowin, 1'b1);
    chk("ldb_blocked", ws_fwd_blocked, 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
    exp_instret++;
    chk("ldb_instret", instret, exp_instret);

    offer(1'b1, 3'd4, 5'd9, 32'h1c000202);
    tick();
    ms_to_ws_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h8001BEEF;
    #1;
    chk("ldhu_wdata", rf_wdata, 32'h00008001);
    chk("ldhu_rf_we", rf_we, 4'hf);
    chk("ldhu_allowin", ws_allowin, 1'b1);
    chk("ldhu_blocked", ws_fwd_blocked, 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
    exp_instret++;
    chk("ldhu_instret", instret, exp_instret);

    prev_res = 32'd0;
    for (int i = 0; i < 3; i++) begin
      offer(1'b0, 3'd0, 5'(i + 1), $urandom);
      #1;
      chk("b2b_allowin", ws_allowin, 1'b1);
      if (i > 0) begin
        chk("b2b_rf_we", rf_we, 4'hf);
        chk("b2b_wdata", rf_wdata, prev_res);
        chk("b2b_waddr", rf_waddr, 5'(i));
      end
      prev_res = ms_res;
      tick();
    end
    ms_to_ws_valid = 1'b0;
    #1;
    chk("b2b_last_rf_we", rf_we, 4'hf);
    chk("b2b_last_wdata", rf_wdata, prev_res);
    tick();
    exp_instret += 3;
    chk("b2b_instret", instret, exp_instret);

    offer(1'b1, 3'd0, 5'd11, 32'h1c000300);
    tick();
    ms_to_ws_valid = 1'b0;
    #1 chk("rst_wait_blocked", ws_fwd_blocked, 1'b1);
    resetn = 1'b0;
    #1;
    exp_instret = 0;
    chk("rst_mid_instret", instret, exp_instret);
    chk("rst_mid_fwd_valid", ws_fwd_valid, 1'b0);
    tick();
    resetn = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEADBEEF;
    #1;
    chk("rst_late_ok_rf_we", rf_we, 4'h0);
    chk("rst_late_ok_fwd", ws_fwd_valid, 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
    chk("rst_late_ok_instret", instret, exp_instret);

    for (int c = 0; c < 400; c++) begin
      logic   occ, ret, fv, dok, take;
      ins_t   cur, nxt;
      logic [31:0] ev;
      dok = ($urandom_range(0, 2) == 0);
      data_sram_data_ok = dok;
      data_sram_rdata = $urandom;
      nxt.ld = $urandom_range(0, 1) == 1;
      nxt.op = 3'($urandom_range(0, 7));
      nxt.gr_we = $urandom_range(0, 3) != 0;
      nxt.dest = 5'($urandom_range(0, 31));
      nxt.res = $urandom;
      take = $urandom_range(0, 3) != 0;
      ms_to_ws_valid = take;
      ms_is_load = nxt.ld;
      ms_ld_op = nxt.op;
      ms_gr_we = nxt.gr_we;
      ms_dest = nxt.dest;
      ms_res = nxt.res;
      ms_pc = $urandom;
      occ = wb_q.size() != 0;
      cur = occ ? wb_q[0] : nxt;
      ret = occ && (!cur.ld || dok);
      fv = occ && cur.gr_we && cur.dest != 5'd0;
      ev = cur.ld ? load_val(cur.op, cur.res[1:0], data_sram_rdata) : cur.res;
      #1;
      chk("rnd_allowin", ws_allowin, !occ || ret);
      chk("rnd_rf_we", rf_we, (ret && cur.gr_we) ? 4'hf : 4'h0);
      chk("rnd_fwd_valid", ws_fwd_valid, fv);
      chk("rnd_fwd_blocked", ws_fwd_blocked, fv && cur.ld && !dok);
      chk("rnd_instret", instret, exp_instret);
      if (ret && cur.gr_we) begin
        chk("rnd_waddr", rf_waddr, cur.dest);
        chk("rnd_wdata", rf_wdata, ev);
        chk("rnd_fwd_data", ws_fwd_data, ev);
      end
      if (fv) chk("rnd_fwd_dest", ws_fwd_dest, cur.dest);
      tick();
      if (ret) begin
        void'(wb_q.pop_front());
        exp_instret++;
      end
      if ((!occ || ret) && take) wb_q.push_back(nxt);
    end
    ms_to_ws_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    #1 chk("final_instret", instret, exp_instret);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
